// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, status bits,
// receive FSM states and oversampling ratio.
package uart_pkg;

  localparam logic [1:0] RegRxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;

  localparam int StNotEmpty = 0;
  localparam int StFull     = 1;
  localparam int StFrameErr = 2;
  localparam int StOverrun  = 3;

  localparam int Oversample = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; pointers carry an extra wrap bit
// so full and empty are told apart without a counter.
module uart_rx_fifo #(
  parameter int Depth = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  output logic       o_full
);

  localparam int AW = $clog2(Depth);

  logic [7:0]  r_mem [Depth];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot the same-cycle push needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with byte FIFO and a registered
// bus slave exposing RXDATA and STATUS.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int RxFifoDepth    = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        uart_rx_i,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  output logic        rx_irq_o
);

  localparam int ClksPerSample = ClockFrequency / (BaudRate * Oversample);
  localparam int TW = (ClksPerSample > 1) ? $clog2(ClksPerSample) : 1;
  localparam logic [3:0] HalfBit = 4'(Oversample / 2 - 1);
  localparam logic [3:0] FullBit = 4'(Oversample - 1);

  logic          r_sync1, r_sync2, r_prev;
  logic [TW-1:0] r_tick_cnt;
  uart_state_e   r_state, w_state_d;
  logic [3:0]    r_os, w_os_d;
  logic [2:0]    r_bit, w_bit_d;
  logic [7:0]    r_shift, w_shift_d;
  logic          r_frame_err, r_overrun;
  logic          r_rvalid;
  logic [31:0]   r_rdata, w_rdata;
  logic          w_tick, w_fall, w_push, w_fe_set;
  logic          w_rd, w_wr, w_sel_data, w_sel_stat, w_pop;
  logic          w_empty, w_full, w_ovr_set;
  logic [1:0]    w_clr;
  logic [7:0]    w_fifo_rdata;
  logic [3:0]    w_status;
  logic          w_unused;

  assign w_unused = ^{device_addr_i[31:4], device_addr_i[1:0],
                      device_be_i[3:1], device_wdata_i[31:4],
                      device_wdata_i[1:0]};

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;
  assign w_tick = (r_state != IDLE) &&
                  (r_tick_cnt == TW'(ClksPerSample - 1));

  // Held at zero in IDLE, so every START begins a fresh sample period.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni)             r_tick_cnt <= '0;
    else if (r_state == IDLE)    r_tick_cnt <= '0;
    else if (w_tick)             r_tick_cnt <= '0;
    else                         r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_state <= IDLE;
      r_os    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_d;
      r_os    <= w_os_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_os_d    = r_os;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_push    = 1'b0;
    w_fe_set  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_d = START;
          w_os_d    = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_os == HalfBit) begin
            w_os_d    = '0;
            w_bit_d   = '0;
            w_state_d = r_sync2 ? IDLE : DATA;
          end else begin
            w_os_d = r_os + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_os == FullBit) begin
            w_os_d    = '0;
            w_shift_d = {r_sync2, r_shift[7:1]};
            w_bit_d   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_d = STOP;
          end else begin
            w_os_d = r_os + 4'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_os == FullBit) begin
            w_os_d    = '0;
            w_state_d = IDLE;
            w_push    = r_sync2;
            w_fe_set  = ~r_sync2;
          end else begin
            w_os_d = r_os + 4'd1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign w_rd       = device_req_i & ~device_we_i;
  assign w_wr       = device_req_i & device_we_i & device_be_i[0];
  assign w_sel_data = (device_addr_i[3:2] == RegRxData);
  assign w_sel_stat = (device_addr_i[3:2] == RegStatus);
  assign w_pop      = w_rd & w_sel_data & ~w_empty;
  assign w_clr      = (w_wr & w_sel_stat) ? device_wdata_i[3:2] : 2'b00;
  assign w_ovr_set  = w_push & w_full & ~w_pop;

  uart_rx_fifo #(
    .Depth(RxFifoDepth)
  ) u_fifo (
    .i_clk  (clk_sys_i),
    .i_rst_n(rst_sys_ni),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(r_shift),
    .o_rdata(w_fifo_rdata),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  assign w_status = {r_overrun, r_frame_err, w_full, ~w_empty};

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      unique case (1'b1)
        w_sel_data: w_rdata = w_empty ? 32'd0 : {24'd0, w_fifo_rdata};
        w_sel_stat: w_rdata = {28'd0, w_status};
        default:    w_rdata = '0;
      endcase
    end
  end

  // A flag set in the same cycle as its clear stays set.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_frame_err <= (r_frame_err & ~w_clr[0]) | w_fe_set;
      r_overrun   <= (r_overrun & ~w_clr[1]) | w_ovr_set;
      r_rvalid    <= device_req_i;
      r_rdata     <= w_rdata;
    end
  end

  assign device_rvalid_o = r_rvalid;
  assign device_rdata_o  = r_rdata;
  assign rx_irq_o        = ~w_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit:
// framing, glitch, errors, overrun, pop/push race, reset.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;
  logic [31:0] d;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .ClockFrequency(1_600_000),
    .BaudRate      (100_000),
    .RxFifoDepth   (8)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .uart_rx_i      (rx),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .rx_irq_o       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (16) @(posedge clk);
    end
    #1 rx = stop;
    repeat (16) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] q);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rvalid_rd", {31'd0, rvalid}, 32'd1);
    q = rdata;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = a; be = 4'h1; wdata = v;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    chk("rvalid_wr", {31'd0, rvalid}, 32'd1);
    chk("rdata_wr", rdata, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    send_frame(8'hA5, 1'b1);
    chk("a5_irq", {31'd0, irq}, 32'd1);
    bus_rd(32'h4, d); chk("a5_status", d, 32'h1);
    bus_rd(32'h0, d); chk("a5_data", d, 32'h0000_00A5);
    chk("a5_irq_clr", {31'd0, irq}, 32'd0);
    bus_rd(32'h4, d); chk("a5_status_clr", d, 32'h0);

    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (24) @(posedge clk);
    bus_rd(32'h4, d); chk("glitch_status", d, 32'h0);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    send_frame(8'h3C, 1'b0);
    bus_rd(32'h4, d); chk("ferr_status", d, 32'h4);
    chk("ferr_irq", {31'd0, irq}, 32'd0);
    bus_wr(32'h4, 32'h4);
    bus_rd(32'h4, d); chk("ferr_w1c", d, 32'h0);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    bus_rd(32'h4, d); chk("ovr_status", d, 32'hB);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(32'h0, d); chk("ovr_data", d, 32'(i));
    end
    bus_rd(32'h0, d); chk("empty_read", d, 32'h0);
    bus_rd(32'h4, d); chk("empty_status", d, 32'h8);
    bus_rd(32'h8, d); chk("unmapped_rd", d, 32'h0);
    bus_wr(32'h4, 32'h8);
    bus_rd(32'h4, d); chk("ovr_w1c", d, 32'h0);

    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1);
    bus_rd(32'h4, d); chk("full_status", d, 32'h3);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (153) @(posedge clk);
        bus_rd(32'h0, d);
        chk("race_data", d, 32'h11);
      end
    join
    bus_rd(32'h4, d); chk("race_status", d, 32'h3);
    for (int i = 0; i < 7; i++) begin
      bus_rd(32'h0, d); chk("race_drain", d, 32'h12 + 32'(i));
    end
    bus_rd(32'h0, d); chk("race_last", d, 32'h55);
    bus_rd(32'h4, d); chk("race_empty", d, 32'h0);

    send_frame(8'h66, 1'b1);
    send_frame(8'h77, 1'b1);
    bus_rd(32'h4, d); chk("pre_rst_status", d, 32'h1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (60) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    bus_rd(32'h4, d); chk("post_rst_status", d, 32'h0);
    bus_rd(32'h0, d); chk("post_rst_data", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
